io_bus_bridge: RTL and testbench

//   Memory-mapped I/O bridge between the core's data port and data RAM / board peripherals.
//   - Addresses at or above 0xFFFF_F000 go to registered peripherals:
//     LED outputs, synchronized switch inputs, an 8-digit 7-seg display and an optional timer.
//   - All other addresses pass straight through to data RAM.
//   - Combinational read path, so the single-cycle core still completes a load in one cycle.

---
 rtl/io_bus_bridge_pkg.sv | 23 ++
 rtl/io_bus_bridge_seg7_scan.sv | 40 ++++
 rtl/io_bus_bridge.sv | 116 +++++++++++
 tb/tb_io_bus_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_bridge_pkg.sv
// Shared I/O map constants and the hex-to-7-segment table for the I/O bus bridge.
// Pure declarations: no clocks, no latency, no flow control.
package io_bus_bridge_pkg;

   localparam logic [19:0] IO_BASE_HI = 20'hFFFFF;

   localparam logic [11:0] OFF_SEG   = 12'h000;
   localparam logic [11:0] OFF_TIMER = 12'h020;
   localparam logic [11:0] OFF_TDIV  = 12'h024;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;

   // Active-low {DP,G,F,E,D,C,B,A}; entry 0 is the rightmost element
   localparam logic [15:0][7:0] HEX7SEG_TBL = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] hex7seg(input logic [3:0] nib);
      return HEX7SEG_TBL[nib];
   endfunction

endpackage

// File: rtl/io_bus_bridge_seg7_scan.sv
// Multiplexed 8-digit 7-segment scanner; each digit lit for SCAN_DIV cycles, DP kept dark.
// Latency: outputs registered one cycle behind dig_idx/data; no backpressure (free-running).
module io_bus_bridge_seg7_scan
   import io_bus_bridge_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] data,
   output logic [7:0]  dig_en_o,
   output logic [7:0]  seg_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] scan_cnt;
   logic [2:0]       dig_idx;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scan_cnt <= '0;
         dig_idx  <= '0;
         dig_en_o <= 8'hFF;
         seg_o    <= 8'hFF;
      end else begin
         if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + CNT_ONE;
         end
         dig_en_o <= ~(8'd1 << dig_idx);
         seg_o    <= hex7seg(data[{dig_idx, 2'b00} +: 4]);
      end
   end

endmodule

// File: rtl/io_bus_bridge.sv
// Core data-port bridge: 0xFFFFF_xxx to LED/switch/7-seg (+timer with IO_BUS_BRIDGE_TIMER_EN), rest to DRAM.
// Latency: reads combinational, writes land on the strobe edge; no backpressure, core never stalls.
module io_bus_bridge
   import io_bus_bridge_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int SW_W     = 24
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [31:0]     cpu_addr_i,
   input  logic            cpu_we_i,
   input  logic [31:0]     cpu_wdata_i,
   output logic [31:0]     cpu_rdata_o,
   output logic [31:0]     dram_addr_o,
   output logic            dram_we_o,
   output logic [31:0]     dram_wdata_o,
   input  logic [31:0]     dram_rdata_i,
   input  logic [SW_W-1:0] sw_i,
   output logic [SW_W-1:0] led_o,
   output logic [7:0]      dig_en_o,
   output logic [7:0]      seg_o
);

   logic        io_hit;
   logic [11:0] io_off;
   logic        wr_seg;
   logic        wr_led;
   logic [31:0] seg_data;
   logic [SW_W-1:0] led_q;
   logic [SW_W-1:0] sw_meta;
   logic [SW_W-1:0] sw_sync;
   logic [31:0] io_rdata;

   assign io_hit = (cpu_addr_i[31:12] == IO_BASE_HI);
   assign io_off = cpu_addr_i[11:0];

   // Peripherals are word-only: the byte offset is part of the offset compare.
   assign wr_seg = cpu_we_i & io_hit & (io_off == OFF_SEG);
   assign wr_led = cpu_we_i & io_hit & (io_off == OFF_LED);

   assign dram_addr_o  = cpu_addr_i;
   assign dram_wdata_o = cpu_wdata_i;
   assign dram_we_o    = cpu_we_i & ~io_hit;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         seg_data <= '0;
         led_q    <= '0;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         if (wr_seg) seg_data <= cpu_wdata_i;
         if (wr_led) led_q    <= cpu_wdata_i[SW_W-1:0];
         sw_meta <= sw_i;
         sw_sync <= sw_meta;
      end
   end

   assign led_o = led_q;

`ifdef IO_BUS_BRIDGE_TIMER_EN
   logic        wr_timer;
   logic        wr_tdiv;
   logic        tick;
   logic [31:0] timer_q;
   logic [31:0] tdiv_q;
   logic [31:0] prescale_q;

   assign wr_timer = cpu_we_i & io_hit & (io_off == OFF_TIMER);
   assign wr_tdiv  = cpu_we_i & io_hit & (io_off == OFF_TDIV);
   assign tick     = (prescale_q == tdiv_q);

   // Any timer-register write restarts the prescaler and wins over a pending tick.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         timer_q    <= '0;
         tdiv_q     <= '0;
         prescale_q <= '0;
      end else begin
         if (wr_tdiv) tdiv_q <= cpu_wdata_i;
         if (wr_timer || wr_tdiv || tick) prescale_q <= '0;
         else                             prescale_q <= prescale_q + 32'd1;
         if (wr_timer)            timer_q <= cpu_wdata_i;
         else if (tick && !wr_tdiv) timer_q <= timer_q + 32'd1;
      end
   end
`endif

   always_comb begin
      io_rdata = '0;
      case (io_off)
         OFF_SEG: io_rdata = seg_data;
         OFF_LED: io_rdata[SW_W-1:0] = led_q;
         OFF_SW:  io_rdata[SW_W-1:0] = sw_sync;
`ifdef IO_BUS_BRIDGE_TIMER_EN
         OFF_TIMER: io_rdata = timer_q;
         OFF_TDIV:  io_rdata = tdiv_q;
`endif
         default: io_rdata = '0;
      endcase
   end

   assign cpu_rdata_o = io_hit ? io_rdata : dram_rdata_i;

   io_bus_bridge_seg7_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .data     (seg_data),
      .dig_en_o (dig_en_o),
      .seg_o    (seg_o)
   );

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge with a 4-cycle scan period.
// Covers reset, scan order, display data, LED, switch sync, DRAM pass-through and the optional timer.
module tb_io_bus_bridge;

   localparam int SCAN_DIV = 4;
   localparam int SW_W     = 24;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [31:0]     cpu_addr = '0;
   logic            cpu_we = 1'b0;
   logic [31:0]     cpu_wdata = '0;
   logic [31:0]     cpu_rdata;
   logic [31:0]     dram_addr;
   logic            dram_we;
   logic [31:0]     dram_wdata;
   logic [31:0]     dram_rdata = '0;
   logic [SW_W-1:0] sw = '0;
   logic [SW_W-1:0] led;
   logic [7:0]      dig_en;
   logic [7:0]      seg;

   int checks = 0;
   int errors = 0;
   int cyc;
   logic [31:0] seg_model = '0;
   logic [31:0] exp_q[$];
   logic [31:0] exp;

   io_bus_bridge #(
      .SCAN_DIV (SCAN_DIV),
      .SW_W     (SW_W)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .cpu_addr_i   (cpu_addr),
      .cpu_we_i     (cpu_we),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_rdata_o  (cpu_rdata),
      .dram_addr_o  (dram_addr),
      .dram_we_o    (dram_we),
      .dram_wdata_o (dram_wdata),
      .dram_rdata_i (dram_rdata),
      .sw_i         (sw),
      .led_o        (led),
      .dig_en_o     (dig_en),
      .seg_o        (seg)
   );

   always #5 clk = ~clk;

   // Edges seen since the last reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [7:0] hex_ref(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   // {dig_en, seg} expected just after edge c (c >= 1) with display word d
   function automatic logic [31:0] exp_scan(input int c, input logic [31:0] d);
      int k;
      logic [3:0] nib;
      logic [7:0] en;
      k   = ((c - 1) / SCAN_DIV) % 8;
      nib = 4'((d >> (4 * k)) & 32'hF);
      en  = 8'hFF;
      en[k] = 1'b0;
      return {16'h0, en, hex_ref(nib)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
      cpu_addr  = addr;
      cpu_wdata = data;
      cpu_we    = 1'b1;
      step();
      cpu_we = 1'b0;
      if (addr == 32'hFFFF_F000) seg_model = data;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cpu_addr = 32'hFFFF_F060;
      exp_q.push_back({16'h0, 8'hFF, 8'hFF});
      #12;
      exp = exp_q.pop_front();
      checks++;
      if ({dig_en, seg} !== exp[15:0]) begin
         errors++;
         $display("FAIL reset_dark: dig_en/seg=%h expected %h", {dig_en, seg}, exp[15:0]);
      end
      checks++;
      if (led !== '0 || cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_led: led=%h rdata=%h expected 0", led, cpu_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // 33 edges: digit 0 first, advancing every SCAN_DIV edges, back to digit 0 after one frame
   task automatic test_scan(input string name);
      for (int i = 0; i < 8 * SCAN_DIV + 1; i++) begin
         step();
         exp_q.push_back(exp_scan(cyc, seg_model));
         exp = exp_q.pop_front();
         checks++;
         if ({dig_en, seg} !== exp[15:0]) begin
            errors++;
            $display("FAIL %s cyc %0d: dig_en/seg=%h expected %h", name, cyc, {dig_en, seg}, exp[15:0]);
         end
      end
   endtask

   task automatic test_seg_data();
      cpu_write(32'hFFFF_F000, 32'h0000_0008);
      exp_q.push_back(32'h0000_0008);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
         errors++;
         $display("FAIL seg_readback: rdata=%h expected %h", cpu_rdata, exp);
      end
      test_scan("seg_digit");
      cpu_write(32'hFFFF_F000, 32'h89AB_CDEF);
      test_scan("seg_hex");
   endtask

   task automatic test_led();
      cpu_addr  = 32'hFFFF_F060;
      cpu_wdata = 32'hFFFF_FFFF;
      cpu_we    = 1'b1;
      #1;
      checks++;
      if (dram_we !== 1'b0) begin
         errors++;
         $display("FAIL led_dram_we: dram_we=%b expected 0", dram_we);
      end
      step();
      cpu_we = 1'b0;
      checks++;
      if (led !== 24'hFF_FFFF) begin
         errors++;
         $display("FAIL led_out: led=%h expected ffffff", led);
      end
      exp_q.push_back(32'h00FF_FFFF);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
         errors++;
         $display("FAIL led_read: rdata=%h expected %h", cpu_rdata, exp);
      end
   endtask

   task automatic test_switch();
      logic [31:0] tbl [4] = '{32'h0, 32'h0, 32'h0000_A5A5, 32'h0000_A5A5};
      cpu_addr = 32'hFFFF_F070;
      sw = 24'h00A5A5;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         exp_q.push_back(tbl[i]);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL sw_sync edge %0d: rdata=%h expected %h", i, cpu_rdata, exp);
         end
      end
   endtask

   task automatic test_dram();
      cpu_addr  = 32'h0000_0010;
      cpu_wdata = 32'h0000_1234;
      cpu_we    = 1'b1;
      #1;
      checks++;
      if (dram_we !== 1'b1 || dram_addr !== 32'h10 || dram_wdata !== 32'h1234) begin
         errors++;
         $display("FAIL dram_pass: we=%b addr=%h wdata=%h expected 1/00000010/00001234",
                  dram_we, dram_addr, dram_wdata);
      end
      step();
      cpu_we = 1'b0;
      dram_rdata = 32'h0000_DEAD;
      exp_q.push_back(32'h0000_DEAD);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
         errors++;
         $display("FAIL dram_read: rdata=%h expected %h", cpu_rdata, exp);
      end
      cpu_addr  = 32'hFFFF_F100;
      cpu_wdata = 32'h5555_5555;
      cpu_we    = 1'b1;
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp || dram_we !== 1'b0) begin
         errors++;
         $display("FAIL unmapped: rdata=%h dram_we=%b expected %h/0", cpu_rdata, dram_we, exp);
      end
      step();
      cpu_we = 1'b0;
`ifndef IO_BUS_BRIDGE_TIMER_EN
      cpu_write(32'hFFFF_F020, 32'h0000_0077);
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
         errors++;
         $display("FAIL timer_absent: rdata=%h expected %h", cpu_rdata, exp);
      end
`endif
   endtask

`ifdef IO_BUS_BRIDGE_TIMER_EN
   task automatic test_timer();
      logic [31:0] tbl [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
      cpu_write(32'hFFFF_F024, 32'd2);
      cpu_write(32'hFFFF_F020, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         exp_q.push_back(tbl[i]);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL timer_wrap step %0d: rdata=%h expected %h", i, cpu_rdata, exp);
         end
      end
      cpu_write(32'hFFFF_F024, 32'd0);
      step();
      cpu_write(32'hFFFF_F020, 32'd5);
      exp_q.push_back(32'd5);
      exp_q.push_back(32'd6);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
         errors++;
         $display("FAIL timer_write_wins: rdata=%h expected %h", cpu_rdata, exp);
      end
      step();
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
         errors++;
         $display("FAIL timer_tdiv0: rdata=%h expected %h", cpu_rdata, exp);
      end
   endtask
`endif

   task automatic test_reset_mid_scan();
      cpu_write(32'hFFFF_F060, 32'h0012_3456);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dig_en !== 8'hFF || seg !== 8'hFF || led !== '0) begin
         errors++;
         $display("FAIL async_reset: dig_en=%h seg=%h led=%h expected ff/ff/0", dig_en, seg, led);
      end
      seg_model = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      exp_q.push_back({16'h0, 8'hFE, 8'hC0});
      exp = exp_q.pop_front();
      checks++;
      if ({dig_en, seg} !== exp[15:0]) begin
         errors++;
         $display("FAIL reset_restart: dig_en/seg=%h expected %h", {dig_en, seg}, exp[15:0]);
      end
      cpu_addr = 32'hFFFF_F000;
      #1;
      checks++;
      if (cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_seg_data: rdata=%h expected 0", cpu_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_scan("scan_idle");
      test_seg_data();
      test_led();
      test_switch();
      test_dram();
`ifdef IO_BUS_BRIDGE_TIMER_EN
      test_timer();
`endif
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded 200000 time units, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
